// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, two write ports and a per-register busy scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes (and their busy clears) into the read flops.
module reg_file_sb #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     ra1,
    input  logic [ADDR_W-1:0]     ra2,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2,
    output logic                  rd_vld,
    output logic                  rd_hazard,
    input  logic                  wa_en,
    input  logic [ADDR_W-1:0]     wa_addr,
    input  logic [DATA_W-1:0]     wa_data,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  rsv_en,
    input  logic [ADDR_W-1:0]     rsv_addr,
    output logic [2**ADDR_W-1:0]  busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_nxt;
    logic [DATA_W-1:0] op1, op2;
    logic              haz1, haz2;

    // Port B is written last so it wins an address collision with port A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wa_en) regs[wa_addr] <= wa_data;
            if (wb_en) regs[wb_addr] <= wb_data;
        end
    end

    // A reservation is applied after the write clears: the newer instruction keeps ownership.
    always_comb begin
        busy_nxt = busy;
        if (wa_en)  busy_nxt[wa_addr]  = 1'b0;
        if (wb_en)  busy_nxt[wb_addr]  = 1'b0;
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    always_comb begin
        op1  = regs[ra1];
        haz1 = busy[ra1];
        op2  = regs[ra2];
        haz2 = busy[ra2];
`ifdef RF_BYPASS_EN
        if (wb_en && wb_addr == ra1) begin
            op1  = wb_data;
            haz1 = rsv_en && rsv_addr == ra1;
        end else if (wa_en && wa_addr == ra1) begin
            op1  = wa_data;
            haz1 = rsv_en && rsv_addr == ra1;
        end
        if (wb_en && wb_addr == ra2) begin
            op2  = wb_data;
            haz2 = rsv_en && rsv_addr == ra2;
        end else if (wa_en && wa_addr == ra2) begin
            op2  = wa_data;
            haz2 = rsv_en && rsv_addr == ra2;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1       <= '0;
            rd2       <= '0;
            rd_hazard <= 1'b0;
            rd_vld    <= 1'b0;
        end else if (rd_en) begin
            rd1       <= op1;
            rd2       <= op2;
            rd_hazard <= haz1 | haz2;
            rd_vld    <= 1'b1;
        end else begin
            rd1       <= '0;
            rd2       <= '0;
            rd_hazard <= 1'b0;
            rd_vld    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed test-plan steps, then randomized traffic against an array model.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rd_en = 1'b0;
    logic [3:0]  ra1 = '0, ra2 = '0;
    logic [7:0]  rd1, rd2;
    logic        rd_vld, rd_hazard;
    logic        wa_en = 1'b0, wb_en = 1'b0, rsv_en = 1'b0;
    logic [3:0]  wa_addr = '0, wb_addr = '0, rsv_addr = '0;
    logic [7:0]  wa_data = '0, wb_data = '0;
    logic [15:0] busy;

    logic        w_rd_en = 1'b0;
    logic [4:0]  w_ra1 = '0, w_ra2 = '0;
    logic [15:0] w_rd1, w_rd2;
    logic        w_rd_vld, w_rd_hazard;
    logic        w_wa_en = 1'b0, w_wb_en = 1'b0, w_rsv_en = 1'b0;
    logic [4:0]  w_wa_addr = '0, w_wb_addr = '0, w_rsv_addr = '0;
    logic [15:0] w_wa_data = '0, w_wb_data = '0;
    logic [31:0] w_busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_regs [16];
    logic        m_busy [16];
    logic [7:0]  exp_rd1, exp_rd2;
    logic        exp_vld, exp_hazard;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
        .rd1(rd1), .rd2(rd2), .rd_vld(rd_vld), .rd_hazard(rd_hazard),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy(busy)
    );

    reg_file_sb #(.DATA_W(16), .ADDR_W(5)) dut_wide (
        .clk(clk), .rst(rst),
        .rd_en(w_rd_en), .ra1(w_ra1), .ra2(w_ra2),
        .rd1(w_rd1), .rd2(w_rd2), .rd_vld(w_rd_vld), .rd_hazard(w_rd_hazard),
        .wa_en(w_wa_en), .wa_addr(w_wa_addr), .wa_data(w_wa_data),
        .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
        .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr),
        .busy(w_busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] model_busy_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 8'h00;
            m_busy[i] = 1'b0;
        end
        exp_rd1 = 8'h00; exp_rd2 = 8'h00; exp_vld = 1'b0; exp_hazard = 1'b0;
    endtask

    // One operand as seen by the read flops, given the stimulus currently on the ports.
    task automatic predict(input logic [3:0] a, output logic [7:0] d, output logic h);
        d = m_regs[a];
        h = m_busy[a];
`ifdef RF_BYPASS_EN
        if (wb_en && wb_addr == a) begin
            d = wb_data;
            h = rsv_en && rsv_addr == a;
        end else if (wa_en && wa_addr == a) begin
            d = wa_data;
            h = rsv_en && rsv_addr == a;
        end
`endif
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".rd1"},    32'(rd1),       32'(exp_rd1));
        checkOutput({tag, ".rd2"},    32'(rd2),       32'(exp_rd2));
        checkOutput({tag, ".rd_vld"}, 32'(rd_vld),    32'(exp_vld));
        checkOutput({tag, ".hazard"}, 32'(rd_hazard), 32'(exp_hazard));
        checkOutput({tag, ".busy"},   32'(busy),      32'(model_busy_vec()));
    endtask

    task automatic applyStimulus(
        input logic i_rd_en, input logic [3:0] i_ra1, input logic [3:0] i_ra2,
        input logic i_wa_en, input logic [3:0] i_wa_addr, input logic [7:0] i_wa_data,
        input logic i_wb_en, input logic [3:0] i_wb_addr, input logic [7:0] i_wb_data,
        input logic i_rsv_en, input logic [3:0] i_rsv_addr);
        logic [7:0] d1, d2;
        logic       h1, h2;
        rd_en = i_rd_en; ra1 = i_ra1; ra2 = i_ra2;
        wa_en = i_wa_en; wa_addr = i_wa_addr; wa_data = i_wa_data;
        wb_en = i_wb_en; wb_addr = i_wb_addr; wb_data = i_wb_data;
        rsv_en = i_rsv_en; rsv_addr = i_rsv_addr;
        predict(i_ra1, d1, h1);
        predict(i_ra2, d2, h2);
        exp_vld    = i_rd_en;
        exp_rd1    = i_rd_en ? d1 : 8'h00;
        exp_rd2    = i_rd_en ? d2 : 8'h00;
        exp_hazard = i_rd_en && (h1 || h2);
        if (i_wa_en) begin m_regs[i_wa_addr] = i_wa_data; m_busy[i_wa_addr] = 1'b0; end
        if (i_wb_en) begin m_regs[i_wb_addr] = i_wb_data; m_busy[i_wb_addr] = 1'b0; end
        if (i_rsv_en) m_busy[i_rsv_addr] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    endtask

    function automatic logic [3:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll("reset");

        // Mid-cycle reset: write and reserve r3, start a read, then pull rst between edges.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
        checkAll("pre_rst_wr");
        applyStimulus(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkAll("pre_rst_rd");
        checkOutput("pre_rst_rd1_5a", 32'(rd1), 32'h5A);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checkAll("async_rst");
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 4'd3, 4'd3, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkAll("post_rst_rd");

        // Two write ports, then a read of both.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd2, 8'hA5, 1'b1, 4'd7, 8'h3C, 1'b0, 4'd0);
        applyStimulus(1'b1, 4'd2, 4'd7, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkAll("wr_rd");
        checkOutput("wr_rd1_a5", 32'(rd1), 32'hA5);
        checkOutput("wr_rd2_3c", 32'(rd2), 32'h3C);

        // Write collision on r5: port B must win.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 8'h11, 1'b1, 4'd5, 8'h22, 1'b0, 4'd0);
        applyStimulus(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkAll("collide");
        checkOutput("collide_rd1_22", 32'(rd1), 32'h22);

        // Scoreboard on r4: reserve, hazard read, clear by write, clean reread, reserve+write.
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
        checkAll("rsv4");
        applyStimulus(1'b1, 4'd4, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkAll("rsv4_rd");
        checkOutput("rsv4_hazard_1", 32'(rd_hazard), 32'h1);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4, 8'h99, 1'b0, 4'd0);
        checkAll("clr4");
        checkOutput("clr4_busy4_0", 32'(busy[4]), 32'h0);
        applyStimulus(1'b1, 4'd4, 4'd0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkAll("reread4");
        checkOutput("reread4_99", 32'(rd1), 32'h99);
        applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 8'h44, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4);
        checkAll("rsv_wr4");
        checkOutput("rsv_wr4_busy_1", 32'(busy[4]), 32'h1);

        // Same-cycle write and read of r1.
        applyStimulus(1'b1, 4'd1, 4'd2, 1'b1, 4'd1, 8'h77, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkAll("bypass");
`ifdef RF_BYPASS_EN
        checkOutput("bypass_rd1", 32'(rd1), 32'h77);
`else
        checkOutput("bypass_rd1", 32'(rd1), 32'h00);
`endif
        idle();
        checkAll("idle");

        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), pick_addr(), pick_addr(),
                          1'($urandom_range(0, 1)), pick_addr(), 8'($urandom),
                          1'($urandom_range(0, 2) == 0), pick_addr(), 8'($urandom),
                          1'($urandom_range(0, 2) == 0), pick_addr());
            checkAll("rand");
        end
        idle();

        // Wide configuration: 16-bit data, 32 registers.
        w_wa_en = 1'b1; w_wa_addr = 5'd31; w_wa_data = 16'hBEEF;
        @(posedge clk); #1;
        w_wa_en = 1'b0;
        w_rd_en = 1'b1; w_ra1 = 5'd31; w_ra2 = 5'd30;
        @(posedge clk); #1;
        checkOutput("wide_rd1", 32'(w_rd1), 32'hBEEF);
        checkOutput("wide_rd2", 32'(w_rd2), 32'h0);
        checkOutput("wide_vld", 32'(w_rd_vld), 32'h1);
        w_rd_en = 1'b0;
        w_rsv_en = 1'b1; w_rsv_addr = 5'd31;
        @(posedge clk); #1;
        w_rsv_en = 1'b0;
        checkOutput("wide_busy31", w_busy, 32'h8000_0000);
        checkOutput("wide_vld_drop", 32'(w_rd_vld), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
